// File: rtl/host_loader_pkg.sv
// Shared types and default sizing for the host-side loader and the neuron core it feeds.
// Optional replay support is selected with HOST_LOADER_REPLAY_EN.
package host_loader_pkg;

  localparam int DATA_W_DEF         = 8;
  localparam int THR_W_DEF          = 16;
  localparam int DEPTH_DEF          = 64;
  localparam int COMPUTE_CYCLES_DEF = 64;
  localparam int RES_W_DEF          = 16;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    BURST,
    THRESH,
    WAIT,
    CAPTURE,
    RESULT,
    RELEASE
  } loader_state_t;

endpackage

// File: rtl/loader_buffer.sv
// DEPTH x DATA_W staging buffer: one synchronous write port, one combinational read port.
// With HOST_LOADER_REPLAY_EN the contents reset to zero so an early replay is well defined.
module loader_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
`ifdef HOST_LOADER_REPLAY_EN
  input  logic              rst,
`endif
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[wr_addr] = wr_data;
  end

`ifdef HOST_LOADER_REPLAY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end
`else
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
`endif

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/host_loader.sv
// Host-side initiator: buffers DEPTH source words, replays them as a gap-free burst into the
// neuron core, hands over the threshold, waits out compute and returns the result.
// Define HOST_LOADER_REPLAY_EN to add the `replay` input (re-burst the previous buffer).
module host_loader
  import host_loader_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int THR_W          = THR_W_DEF,
  parameter int DEPTH          = DEPTH_DEF,
  parameter int COMPUTE_CYCLES = COMPUTE_CYCLES_DEF,
  parameter int RES_W          = RES_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef HOST_LOADER_REPLAY_EN
  input  logic              replay,
`endif
  input  logic [THR_W-1:0]  thr_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              chip_sel,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic [THR_W-1:0]  thr_data,
  output logic              threshold_ready,
  input  logic [RES_W-1:0]  chip_result,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
  output logic              busy
);

  localparam int CNT_W  = $clog2(DEPTH);
  localparam int WAIT_W = $clog2(COMPUTE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEPTH - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(COMPUTE_CYCLES - 1);

  loader_state_t     state_q, state_d;
  logic [CNT_W-1:0]  fill_cnt_q, fill_cnt_d;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [THR_W-1:0]  thr_lat_q, thr_lat_d;
  logic              chip_sel_q, chip_sel_d;
  logic              wr_en_q, wr_en_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [THR_W-1:0]  thr_data_q, thr_data_d;
  logic              threshold_ready_q, threshold_ready_d;
  logic              in_ready_q, in_ready_d;
  logic              res_valid_q, res_valid_d;
  logic [RES_W-1:0]  res_data_q, res_data_d;
  logic              busy_q, busy_d;

  logic              fill_fire;
  logic              res_fire;
  logic [DATA_W-1:0] buf_rd_data;

  assign fill_fire = in_valid & in_ready_q;
  assign res_fire  = res_valid_q & res_ready;

  // Read address tracks the next burst index so wr_data is registered alongside wr_en.
  loader_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (CNT_W)
  ) u_buffer (
    .clk     (clk),
`ifdef HOST_LOADER_REPLAY_EN
    .rst     (rst),
`endif
    .we      (fill_fire),
    .wr_addr (fill_cnt_q),
    .wr_data (in_data),
    .rd_addr (burst_cnt_d),
    .rd_data (buf_rd_data)
  );

  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    burst_cnt_d = burst_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    thr_lat_d   = thr_lat_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          thr_lat_d = thr_in;
          state_d   = FILL;
        end
`ifdef HOST_LOADER_REPLAY_EN
        else if (replay) begin
          thr_lat_d = thr_in;
          state_d   = BURST;
        end
`endif
      end
      FILL: begin
        if (fill_fire) begin
          if (fill_cnt_q == CNT_LAST) begin
            fill_cnt_d = '0;
            state_d    = BURST;
          end else begin
            fill_cnt_d = fill_cnt_q + 1'b1;
          end
        end
      end
      BURST: begin
        if (burst_cnt_q == CNT_LAST) begin
          burst_cnt_d = '0;
          state_d     = THRESH;
        end else begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
      end
      THRESH: state_d = WAIT;
      WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          wait_cnt_d = '0;
          state_d    = CAPTURE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      CAPTURE: state_d = RESULT;
      RESULT:  if (res_fire) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so every port comes straight from a flop.
    in_ready_d        = (state_d == FILL);
    chip_sel_d        = state_d inside {BURST, THRESH, WAIT, CAPTURE, RESULT};
    wr_en_d           = (state_d == BURST);
    wr_data_d         = (state_d == BURST) ? buf_rd_data : '0;
    threshold_ready_d = (state_d == THRESH);
    thr_data_d        = (state_d == THRESH) ? thr_lat_q : thr_data_q;
    res_valid_d       = (state_d == RESULT);
    res_data_d        = (state_q == CAPTURE) ? chip_result : res_data_q;
    busy_d            = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= IDLE;
      fill_cnt_q        <= '0;
      burst_cnt_q       <= '0;
      wait_cnt_q        <= '0;
      thr_lat_q         <= '0;
      chip_sel_q        <= 1'b0;
      wr_en_q           <= 1'b0;
      wr_data_q         <= '0;
      thr_data_q        <= '0;
      threshold_ready_q <= 1'b0;
      in_ready_q        <= 1'b0;
      res_valid_q       <= 1'b0;
      res_data_q        <= '0;
      busy_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      fill_cnt_q        <= fill_cnt_d;
      burst_cnt_q       <= burst_cnt_d;
      wait_cnt_q        <= wait_cnt_d;
      thr_lat_q         <= thr_lat_d;
      chip_sel_q        <= chip_sel_d;
      wr_en_q           <= wr_en_d;
      wr_data_q         <= wr_data_d;
      thr_data_q        <= thr_data_d;
      threshold_ready_q <= threshold_ready_d;
      in_ready_q        <= in_ready_d;
      res_valid_q       <= res_valid_d;
      res_data_q        <= res_data_d;
      busy_q            <= busy_d;
    end
  end

  assign in_ready        = in_ready_q;
  assign chip_sel        = chip_sel_q;
  assign wr_en           = wr_en_q;
  assign wr_data         = wr_data_q;
  assign thr_data        = thr_data_q;
  assign threshold_ready = threshold_ready_q;
  assign res_valid       = res_valid_q;
  assign res_data        = res_data_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_host_loader.sv
// Self-checking bench for host_loader: a table of jobs driven with random data and stalls,
// checked cycle by cycle against the load/burst/threshold/wait/result timeline.
module tb_host_loader;
  import host_loader_pkg::*;

  localparam int DATA_W = DATA_W_DEF;
  localparam int THR_W  = THR_W_DEF;
  localparam int DEPTH  = DEPTH_DEF;
  localparam int CYCLES = COMPUTE_CYCLES_DEF;
  localparam int RES_W  = RES_W_DEF;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              replay;
  logic [THR_W-1:0]  thr_in;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              chip_sel;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic [THR_W-1:0]  thr_data;
  logic              threshold_ready;
  logic [RES_W-1:0]  chip_result;
  logic              res_valid;
  logic              res_ready;
  logic [RES_W-1:0]  res_data;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int cur_job = -1;

  typedef struct {
    logic [THR_W-1:0] thr;
    int               valid_pct;
    bit               counting;
    int               res_wait;
    bit               poke_start;
    int               reset_k;
    bit               use_replay;
    bit               with_replay;
    bit               exp_fill;
    logic [THR_W-1:0] exp_thr;
  } job_t;

  job_t jobs[$];
  logic [DATA_W-1:0] last_words[$];

  host_loader dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
`ifdef HOST_LOADER_REPLAY_EN
    .replay          (replay),
`endif
    .thr_in          (thr_in),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .chip_sel        (chip_sel),
    .wr_en           (wr_en),
    .wr_data         (wr_data),
    .thr_data        (thr_data),
    .threshold_ready (threshold_ready),
    .chip_result     (chip_result),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_data        (res_data),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL job%0d %s at %0t: got 0x%0h, expected 0x%0h", cur_job, name, $time, act, exp);
    end
  endtask

  // Each cycle boundary is a falling edge; the core result changes every cycle so capture timing shows.
  task automatic nextCycle();
    @(negedge clk);
    chip_result = RES_W'($urandom);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_chip_sel"}, 32'(chip_sel), 0);
    checkOutput({tag, "_wr_en"}, 32'(wr_en), 0);
    checkOutput({tag, "_wr_data"}, 32'(wr_data), 0);
    checkOutput({tag, "_thr_data"}, 32'(thr_data), 0);
    checkOutput({tag, "_thr_ready"}, 32'(threshold_ready), 0);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 0);
    checkOutput({tag, "_res_valid"}, 32'(res_valid), 0);
    checkOutput({tag, "_res_data"}, 32'(res_data), 0);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic applyStimulus(input job_t j);
    logic [DATA_W-1:0] words[$];
    logic [RES_W-1:0]  exp_res;
    int pushed;
    int guard;

    nextCycle();
    checkOutput("idle_busy", 32'(busy), 0);
    checkOutput("idle_in_ready", 32'(in_ready), 0);
    thr_in = j.thr;
    if (j.use_replay) begin
      replay = 1'b1;
    end else begin
      start  = 1'b1;
      replay = j.with_replay;
    end
    nextCycle();
    start  = 1'b0;
    replay = 1'b0;
    thr_in = THR_W'($urandom);

    if (j.exp_fill) begin
      pushed = 0;
      guard  = 0;
      while (pushed < DEPTH && guard < 4000) begin
        checkOutput("fill_in_ready", 32'(in_ready), 1);
        checkOutput("fill_chip_sel", 32'(chip_sel), 0);
        checkOutput("fill_wr_en", 32'(wr_en), 0);
        checkOutput("fill_busy", 32'(busy), 1);
        in_valid = ($urandom_range(99) < j.valid_pct);
        in_data  = j.counting && in_valid ? DATA_W'(pushed) : DATA_W'($urandom);
        if (in_valid) begin
          words.push_back(in_data);
          pushed++;
        end
        guard++;
        nextCycle();
      end
      in_valid = 1'b0;
      in_data  = '0;
      if (pushed < DEPTH) begin
        checkOutput("fill_timeout", 32'(pushed), 32'(DEPTH));
        return;
      end
      last_words = words;
    end else begin
      words = last_words;
    end

    for (int k = 0; k < DEPTH; k++) begin
      checkOutput("burst_wr_en", 32'(wr_en), 1);
      checkOutput("burst_chip_sel", 32'(chip_sel), 1);
      checkOutput("burst_wr_data", 32'(wr_data), 32'(words[k]));
      checkOutput("burst_in_ready", 32'(in_ready), 0);
      checkOutput("burst_thr_ready", 32'(threshold_ready), 0);
      if (k == j.reset_k) begin
        rst = 1'b1;
        #1;
        checkAllZero("reset");
        nextCycle();
        rst = 1'b0;
`ifdef HOST_LOADER_REPLAY_EN
        foreach (last_words[i]) last_words[i] = '0;
`endif
        return;
      end
      nextCycle();
    end

    checkOutput("thresh_ready", 32'(threshold_ready), 1);
    checkOutput("thresh_wr_en", 32'(wr_en), 0);
    checkOutput("thresh_data", 32'(thr_data), 32'(j.exp_thr));
    checkOutput("thresh_chip_sel", 32'(chip_sel), 1);
    nextCycle();

    for (int w = 0; w < CYCLES; w++) begin
      start = j.poke_start && (w == 10);
      if (start) thr_in = ~j.thr;
      checkOutput("wait_chip_sel", 32'(chip_sel), 1);
      checkOutput("wait_thr_ready", 32'(threshold_ready), 0);
      checkOutput("wait_thr_data", 32'(thr_data), 32'(j.exp_thr));
      checkOutput("wait_res_valid", 32'(res_valid), 0);
      checkOutput("wait_busy", 32'(busy), 1);
      nextCycle();
    end
    start = 1'b0;

    checkOutput("capture_res_valid", 32'(res_valid), 0);
    checkOutput("capture_chip_sel", 32'(chip_sel), 1);
    exp_res = chip_result;
    nextCycle();

    for (int r = 0; r < j.res_wait; r++) begin
      checkOutput("result_stall_valid", 32'(res_valid), 1);
      checkOutput("result_stall_data", 32'(res_data), 32'(exp_res));
      checkOutput("result_stall_busy", 32'(busy), 1);
      checkOutput("result_stall_chip_sel", 32'(chip_sel), 1);
      nextCycle();
    end
    checkOutput("result_valid", 32'(res_valid), 1);
    checkOutput("result_data", 32'(res_data), 32'(exp_res));
    res_ready = 1'b1;
    nextCycle();
    res_ready = 1'b0;

    checkOutput("release_res_valid", 32'(res_valid), 0);
    checkOutput("release_chip_sel", 32'(chip_sel), 0);
    checkOutput("release_busy", 32'(busy), 1);
    nextCycle();

    for (int i = 0; i < 3; i++) begin
      checkOutput("after_busy", 32'(busy), 0);
      checkOutput("after_chip_sel", 32'(chip_sel), 0);
      checkOutput("after_res_valid", 32'(res_valid), 0);
      nextCycle();
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) last_words.push_back('0);

`ifdef HOST_LOADER_REPLAY_EN
    jobs.push_back(job_t'{16'h0A5A, 100, 1'b0, 1, 1'b0, -1, 1'b1, 1'b0, 1'b0, 16'h0A5A});
`endif
    jobs.push_back(job_t'{16'h0123, 100, 1'b1, 0, 1'b0, -1, 1'b0, 1'b0, 1'b1, 16'h0123});
    jobs.push_back(job_t'{16'hBEEF, 40, 1'b0, 2, 1'b0, -1, 1'b0, 1'b0, 1'b1, 16'hBEEF});
    jobs.push_back(job_t'{16'h7001, 70, 1'b0, 10, 1'b0, -1, 1'b0, 1'b0, 1'b1, 16'h7001});
    jobs.push_back(job_t'{16'h4242, 90, 1'b0, 1, 1'b1, -1, 1'b0, 1'b0, 1'b1, 16'h4242});
    jobs.push_back(job_t'{16'hDEAD, 100, 1'b0, 0, 1'b0, 20, 1'b0, 1'b0, 1'b1, 16'hDEAD});
`ifdef HOST_LOADER_REPLAY_EN
    jobs.push_back(job_t'{16'h1357, 100, 1'b0, 0, 1'b0, -1, 1'b1, 1'b0, 1'b0, 16'h1357});
`endif
    jobs.push_back(job_t'{16'h0F0F, 55, 1'b0, 3, 1'b0, -1, 1'b0, 1'b0, 1'b1, 16'h0F0F});
`ifdef HOST_LOADER_REPLAY_EN
    jobs.push_back(job_t'{16'h00FF, 100, 1'b0, 4, 1'b0, -1, 1'b1, 1'b0, 1'b0, 16'h00FF});
    jobs.push_back(job_t'{16'h2468, 80, 1'b0, 0, 1'b0, -1, 1'b0, 1'b1, 1'b1, 16'h2468});
`endif

    rst         = 1'b1;
    start       = 1'b0;
    replay      = 1'b0;
    thr_in      = '0;
    in_valid    = 1'b0;
    in_data     = '0;
    res_ready   = 1'b0;
    chip_result = '0;
    repeat (3) nextCycle();
    checkAllZero("por");
    rst = 1'b0;

    foreach (jobs[i]) begin
      cur_job = i;
      applyStimulus(jobs[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
